// File: rtl/instruction_fetch_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction fetch queue.
// master = fetch/decode side (testbench), slave = the queue itself.
interface instruction_fetch_queue_if #(
    parameter int ADDR_W = 2
);
    logic [31:0]     InInstruction;
    logic [31:0]     InNextInstruct;
    logic            InValid;
    logic            InReady;
    logic [31:0]     OutInstruction;
    logic [31:0]     OutNextInstruct;
    logic            OutValid;
    logic            OutReady;
    logic            Flush;
    logic [ADDR_W:0] Count;

    modport master (
        output InInstruction, InNextInstruct, InValid, OutReady, Flush,
        input  InReady, OutInstruction, OutNextInstruct, OutValid, Count
    );

    modport slave (
        input  InInstruction, InNextInstruct, InValid, OutReady, Flush,
        output InReady, OutInstruction, OutNextInstruct, OutValid, Count
    );
endinterface

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: FIFO of {instruction, PC+4} between fetch and
// decode. Flush empties it on a redirect so wrong-path words never reach
// decode. Optional zero-latency pass-through when empty: define
// IFQ_BYPASS_EN.
module instruction_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input logic                      Clk,
    input logic                      Reset,
    instruction_fetch_queue_if.slave ifq
);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [31:0]       instr_mem_q [DEPTH];
    logic [31:0]       next_mem_q  [DEPTH];
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic              empty;
    logic              full;
    logic              queue_valid;
    logic              bypass;
    logic              in_ready;
    logic              out_valid;
    logic              write_en;
    logic              read_en;
    logic [31:0]       out_instr;
    logic [31:0]       out_next;

    // Handshake decode and head-of-queue output mux.
    always_comb begin
        empty       = (count_q == '0);
        full        = (count_q == FULL_CNT);
        queue_valid = ~empty & ~ifq.Flush;
`ifdef IFQ_BYPASS_EN
        // Empty queue with a live fetch word: present it to decode directly.
        bypass      = empty & ifq.InValid & ~ifq.Flush & Reset;
`else
        bypass      = 1'b0;
`endif
        in_ready    = ~full & ~ifq.Flush & Reset;
        out_valid   = queue_valid | bypass;
        // A bypassed word taken by decode this cycle never enters storage.
        write_en    = ifq.InValid & in_ready & ~(bypass & ifq.OutReady);
        read_en     = queue_valid & ifq.OutReady;

        out_instr   = 32'h0000_0000;
        out_next    = 32'h0000_0000;
`ifdef IFQ_BYPASS_EN
        if (bypass) begin
            out_instr = ifq.InInstruction;
            out_next  = ifq.InNextInstruct;
        end else if (queue_valid) begin
            out_instr = instr_mem_q[rd_ptr_q];
            out_next  = next_mem_q[rd_ptr_q];
        end
`else
        if (queue_valid) begin
            out_instr = instr_mem_q[rd_ptr_q];
            out_next  = next_mem_q[rd_ptr_q];
        end
`endif
    end

    assign ifq.InReady         = in_ready;
    assign ifq.OutValid        = out_valid;
    assign ifq.OutInstruction  = out_instr;
    assign ifq.OutNextInstruct = out_next;
    assign ifq.Count           = count_q;

    // Next pointers and occupancy; flush overrides any push or pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (ifq.Flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (write_en) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            if (read_en) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            case ({write_en, read_en})
                2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
                2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // One register pair per entry, written when the write pointer selects it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Entry storage; cleared on reset.
            always_ff @(posedge Clk or negedge Reset) begin
                if (!Reset) begin
                    instr_mem_q[gi] <= '0;
                    next_mem_q[gi]  <= '0;
                end else if (write_en && (wr_ptr_q == ADDR_W'(gi))) begin
                    instr_mem_q[gi] <= ifq.InInstruction;
                    next_mem_q[gi]  <= ifq.InNextInstruct;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue: a queue-based reference
// model, a table of directed vectors, hand sequences for corner cases and
// a randomized phase. Build with IFQ_BYPASS_EN to check the pass-through.
module tb_instruction_fetch_queue;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic Clk;
    logic rst;
    int   tests;
    int   fails;
    int   cyc;

    logic [63:0] model[$];

    logic        last_ir;
    logic        last_ov;
    logic [31:0] last_oi;
    logic [ADDR_W:0] last_cnt;

    instruction_fetch_queue_if #(.ADDR_W(ADDR_W)) ifq ();

    instruction_fetch_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .Clk   (Clk),
        .Reset (rst),
        .ifq   (ifq)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus, entered and left at the falling edge.
    task automatic step(input bit fl, input bit iv, input logic [31:0] ins,
                        input logic [31:0] nx, input bit ordy);
        bit          e_ir, e_ov, pu, po;
        logic [31:0] e_oi, e_on;
        ifq.Flush          = fl;
        ifq.InValid        = iv;
        ifq.InInstruction  = ins;
        ifq.InNextInstruct = nx;
        ifq.OutReady       = ordy;
        #1;
        e_ir = (model.size() < DEPTH) && !fl && rst;
        e_ov = (model.size() > 0) && !fl;
        e_oi = 32'h0;
        e_on = 32'h0;
        if (e_ov) begin
            e_oi = model[0][63:32];
            e_on = model[0][31:0];
        end else if (BYP && rst && iv && !fl && model.size() == 0) begin
            e_ov = 1'b1;
            e_oi = ins;
            e_on = nx;
        end
        chk("in_ready",  32'(ifq.InReady),  32'(e_ir));
        chk("out_valid", 32'(ifq.OutValid), 32'(e_ov));
        chk("out_instr", ifq.OutInstruction,  e_oi);
        chk("out_next",  ifq.OutNextInstruct, e_on);
        chk("count",     32'(ifq.Count),    32'(model.size()));
        last_ir  = ifq.InReady;
        last_ov  = ifq.OutValid;
        last_oi  = ifq.OutInstruction;
        last_cnt = ifq.Count;
        pu = iv && e_ir;
        po = e_ov && ordy;
        $display("[TB] cyc %0d rst=%0b fl=%0b push=%0b pop=%0b in=%08h out=%08h cnt=%0d",
                 cyc, rst, fl, pu, po, ins, e_oi, model.size());
        @(posedge Clk);
        cyc++;
        if (!rst || fl) begin
            model.delete();
        end else begin
            if (pu) model.push_back({ins, nx});
            if (po) void'(model.pop_front());
        end
        @(negedge Clk);
    endtask

    typedef struct {
        bit          fl;
        bit          iv;
        logic [31:0] ins;
        bit          ordy;
        logic [2:0]  cnt;
        bit          ir;
        bit          ov;
        logic [31:0] oi;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tests = 0;
        fails = 0;
        cyc   = 0;

        // Fill 4, try a 5th, then drain 4 in order.
        tbl[0] = '{0, 1, 32'h1, 0, 3'd0, 1, BYP, BYP ? 32'h1 : 32'h0};
        tbl[1] = '{0, 1, 32'h2, 0, 3'd1, 1, 1, 32'h1};
        tbl[2] = '{0, 1, 32'h3, 0, 3'd2, 1, 1, 32'h1};
        tbl[3] = '{0, 1, 32'h4, 0, 3'd3, 1, 1, 32'h1};
        tbl[4] = '{0, 1, 32'h5, 0, 3'd4, 0, 1, 32'h1};
        tbl[5] = '{0, 0, 32'h0, 1, 3'd4, 0, 1, 32'h1};
        tbl[6] = '{0, 0, 32'h0, 1, 3'd3, 1, 1, 32'h2};
        tbl[7] = '{0, 0, 32'h0, 1, 3'd2, 1, 1, 32'h3};
        tbl[8] = '{0, 0, 32'h0, 1, 3'd1, 1, 1, 32'h4};
        tbl[9] = '{0, 0, 32'h0, 1, 3'd0, 1, 0, 32'h0};

        rst                = 1'b0;
        ifq.Flush          = 1'b0;
        ifq.InValid        = 1'b1;
        ifq.InInstruction  = 32'h0;
        ifq.InNextInstruct = 32'h0;
        ifq.OutReady       = 1'b0;
        @(negedge Clk);

        // Reset held low with a live fetch word.
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 32'h1234_5678, 32'h4, 0);
            chk("rst_count",  32'(last_cnt), 32'd0);
            chk("rst_ov",     32'(last_ov),  32'd0);
            chk("rst_ir",     32'(last_ir),  32'd0);
            chk("rst_oi",     last_oi,       32'd0);
        end
        rst = 1'b1;

        // First push after release, visible next cycle.
        step(0, 1, 32'h2008_0005, 32'h0000_0004, 0);
        chk("t2_ir_after_release", 32'(last_ir), 32'd1);
        chk("t2_ov",    32'(ifq.OutValid),  32'd1);
        chk("t2_instr", ifq.OutInstruction,  32'h2008_0005);
        chk("t2_next",  ifq.OutNextInstruct, 32'h0000_0004);
        chk("t2_count", 32'(ifq.Count),     32'd1);
        step(1, 0, 32'h0, 32'h0, 0);

        // Directed table: full boundary and in-order drain.
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].fl, tbl[i].iv, tbl[i].ins, tbl[i].ins << 2, tbl[i].ordy);
            chk("tbl_count", 32'(last_cnt), 32'(tbl[i].cnt));
            chk("tbl_ir",    32'(last_ir),  32'(tbl[i].ir));
            chk("tbl_ov",    32'(last_ov),  32'(tbl[i].ov));
            chk("tbl_oi",    last_oi,       tbl[i].oi);
        end

        // Steady push+pop at depth 2; pointers wrap several times.
        step(0, 1, 32'hA000_0001, 32'h100, 0);
        step(0, 1, 32'hA000_0002, 32'h104, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, $urandom, $urandom, 1);
            chk("t4_count", 32'(last_cnt), 32'd2);
        end

        // Flush with a simultaneous push at count 3.
        step(0, 1, 32'hA000_0003, 32'h108, 0);
        step(1, 1, 32'hDEAD_BEEF, 32'h10C, 1);
        chk("t5_count", 32'(ifq.Count),    32'd0);
        chk("t5_ov",    32'(ifq.OutValid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 32'h0, 32'h0, 1);
            chk("t5_no_leak", 32'(last_oi == 32'hDEAD_BEEF), 32'd0);
        end
        // Flush held for several cycles.
        for (int i = 0; i < 3; i++) step(1, 1, $urandom, $urandom, 1);

        // Empty queue, fetch word offered with decode ready.
        step(0, 1, 32'h0800_0010, 32'h0000_0014, 1);
        chk("t6_ov",    32'(last_ov),   32'(BYP));
        chk("t6_oi",    last_oi,        BYP ? 32'h0800_0010 : 32'h0);
        chk("t6_count", 32'(ifq.Count), BYP ? 32'd0 : 32'd1);

        // Asynchronous reset in the middle of a cycle.
        step(0, 1, 32'hB000_0001, 32'h200, 0);
        step(0, 1, 32'hB000_0002, 32'h204, 0);
        ifq.InValid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_count", 32'(ifq.Count),    32'd0);
        chk("midrst_ov",    32'(ifq.OutValid), 32'd0);
        chk("midrst_ir",    32'(ifq.InReady),  32'd0);
        chk("midrst_oi",    ifq.OutInstruction, 32'd0);
        model.delete();
        @(posedge Clk);
        @(negedge Clk);
        rst = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(15) == 0), $urandom_range(1), $urandom, $urandom,
                 $urandom_range(1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
